letc_core_timer: RTL and testbench

// - Machine timer feeding the core's timer_irq_pending input; sits directly upstream of the core interrupt path.
// - Holds a 64-bit mtime counter with programmable prescaler and a 64-bit mtimecmp.
// - Raises a registered level IRQ while enabled and mtime >= mtimecmp.
// - Software accesses it through a single-outstanding 32-bit register request/response port.

---
 rtl/letc_core_timer.sv | 158 +++++++++++++++
 tb/tb_letc_core_timer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/letc_core_timer.sv
// Machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, registered level IRQ,
// accessed through a single-outstanding 32-bit register request/response port.
module letc_core_timer #(
   parameter int unsigned PRESCALE_W   = 8,
   parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        timer_irq_pending
);

   localparam logic [2:0] ADDR_MTIME_LO = 3'd0;
   localparam logic [2:0] ADDR_MTIME_HI = 3'd1;
   localparam logic [2:0] ADDR_CMP_LO   = 3'd2;
   localparam logic [2:0] ADDR_CMP_HI   = 3'd3;
   localparam logic [2:0] ADDR_CTRL     = 3'd4;
   localparam logic [2:0] ADDR_PRESCALE = 3'd5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic                  req_ready_d;
   logic                  rsp_valid_d;
   logic [31:0]           rsp_rdata_d;
   logic                  rsp_err_d;
   logic                  irq_d;

   logic [63:0]           mtime_q, mtime_d;
   logic [63:0]           cmp_q, cmp_d;
   logic                  en_q, en_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] cnt_q, cnt_d;

   logic                  tick;
   logic                  accept;
   logic                  addr_err;
   logic [31:0]           rd_val;

   // Read mux sees pre-update register values
   always_comb begin
      rd_val = 32'd0;
      case (req_addr)
         ADDR_MTIME_LO: rd_val = mtime_q[31:0];
         ADDR_MTIME_HI: rd_val = mtime_q[63:32];
         ADDR_CMP_LO:   rd_val = cmp_q[31:0];
         ADDR_CMP_HI:   rd_val = cmp_q[63:32];
         ADDR_CTRL:     rd_val = {31'd0, en_q};
         ADDR_PRESCALE: rd_val = 32'(prescale_q);
         default:       rd_val = 32'd0;
      endcase
   end

   // Next-state, response capture, register writes and timer tick
   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready;
      rsp_valid_d = rsp_valid;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;

      tick       = en_q && (cnt_q == prescale_q);
      mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
      cnt_d      = en_q ? (tick ? '0 : (cnt_q + PRESCALE_W'(1))) : cnt_q;
      cmp_d      = cmp_q;
      en_d       = en_q;
      prescale_d = prescale_q;
      irq_d      = en_q && (mtime_q >= cmp_q);

      accept   = (state_q == IDLE) && req_valid;
      addr_err = (req_addr > ADDR_PRESCALE);

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = RESP;
               req_ready_d = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = addr_err;
               rsp_rdata_d = (req_we || addr_err) ? 32'd0 : rd_val;
               if (req_we) begin
                  // Written mtime half overrides the tick; the other half keeps its pre-tick value
                  case (req_addr)
                     ADDR_MTIME_LO: mtime_d = {mtime_q[63:32], req_wdata};
                     ADDR_MTIME_HI: mtime_d = {req_wdata, mtime_q[31:0]};
                     ADDR_CMP_LO:   cmp_d   = {cmp_q[63:32], req_wdata};
                     ADDR_CMP_HI:   cmp_d   = {req_wdata, cmp_q[31:0]};
                     ADDR_CTRL:     en_d    = req_wdata[0];
                     ADDR_PRESCALE: begin
                        prescale_d = PRESCALE_W'(req_wdata);
                        cnt_d      = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               req_ready_d = 1'b1;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control/response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= IDLE;
         req_ready         <= 1'b1;
         rsp_valid         <= 1'b0;
         rsp_rdata         <= 32'd0;
         rsp_err           <= 1'b0;
         timer_irq_pending <= 1'b0;
      end else begin
         state_q           <= state_d;
         req_ready         <= req_ready_d;
         rsp_valid         <= rsp_valid_d;
         rsp_rdata         <= rsp_rdata_d;
         rsp_err           <= rsp_err_d;
         timer_irq_pending <= irq_d;
      end
   end

   // Timer datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= 64'd0;
         cmp_q      <= MTIMECMP_RST;
         en_q       <= 1'b0;
         prescale_q <= '0;
         cnt_q      <= '0;
      end else begin
         mtime_q    <= mtime_d;
         cmp_q      <= cmp_d;
         en_q       <= en_d;
         prescale_q <= prescale_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_letc_core_timer.sv
// Directed bench for letc_core_timer: reset, prescaler, IRQ compare, wrap, error access, async reset.
module tb_letc_core_timer;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        timer_irq_pending;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [31:0] rdv;
   logic        erv;
   int          acc;

   letc_core_timer dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_we            (req_we),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_rdata         (rsp_rdata),
      .rsp_err           (rsp_err),
      .timer_irq_pending (timer_irq_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: after edge N (sampled #1 later) cyc == N
   always @(posedge clk) cyc <= cyc + 1;

   // One bus transaction; acc = index of the accepting edge
   task automatic bus(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int acc_cyc);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      rsp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL bus_accept_timeout addr=%0d got req_ready=%b want 1", addr, req_ready);
      end
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL rsp_latency addr=%0d got rsp_valid=%b want 1", addr, rsp_valid);
      end
      rd = rsp_rdata;
      er = rsp_err;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
      bus(1'b1, addr, wd, rdv, erv, acc);
   endtask

   task automatic rd_expect(input string name, input logic [2:0] addr, input logic [31:0] exp);
      bus(1'b0, addr, 32'd0, rdv, erv, acc);
      checks++;
      if (rdv !== exp || erv !== 1'b0) begin
         errors++;
         $display("FAIL %s got rdata=%h err=%b want rdata=%h err=0", name, rdv, erv, exp);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 ||
          rsp_err !== 1'b0 || timer_irq_pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b vld=%b rdata=%h err=%b irq=%b want 1 0 0 0 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err, timer_irq_pending);
      end
      repeat (100) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1 || timer_irq_pending !== 1'b0) begin
         errors++;
         $display("FAIL idle_100 got rdy=%b irq=%b want 1 0", req_ready, timer_irq_pending);
      end
      rd_expect("rst_mtime_lo", 3'd0, 32'd0);
      rd_expect("rst_mtime_hi", 3'd1, 32'd0);
      rd_expect("rst_cmp_lo",   3'd2, 32'hFFFF_FFFF);
      rd_expect("rst_cmp_hi",   3'd3, 32'hFFFF_FFFF);
      rd_expect("rst_ctrl",     3'd4, 32'd0);
      rd_expect("rst_prescale", 3'd5, 32'd0);
   endtask

   // prescale=3: mtime ticks at edges E+4, E+8, ... after the ctrl write edge E
   task automatic test_prescale();
      int e, d, exp;
      wr(3'd5, 32'd3);
      rd_expect("prescale_rb", 3'd5, 32'd3);
      wr(3'd4, 32'd1);
      e = acc;
      repeat (40) @(posedge clk);
      bus(1'b0, 3'd0, 32'd0, rdv, erv, acc);
      exp = (acc - 1 - e) / 4;
      checks++;
      if (rdv !== 32'(exp)) begin
         errors++;
         $display("FAIL prescale_count got %0d want %0d", rdv, exp);
      end
      wr(3'd4, 32'd0);
      d = acc;
      exp = (d - e) / 4;
      rd_expect("freeze_a", 3'd0, 32'(exp));
      repeat (10) @(posedge clk);
      rd_expect("freeze_b", 3'd0, 32'(exp));
   endtask

   // prescale=0, cmp=20: mtime==20 after edge E+20, irq set at edge E+21
   task automatic test_irq();
      int e, rise;
      wr(3'd4, 32'd0);
      wr(3'd5, 32'd0);
      wr(3'd0, 32'd0);
      wr(3'd1, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd2, 32'd20);
      wr(3'd4, 32'd1);
      e = acc;
      rise = -1;
      for (int k = 0; k < 40 && rise < 0; k++) begin
         @(negedge clk);
         if (timer_irq_pending === 1'b1) rise = cyc;
      end
      checks++;
      if (rise != e + 21) begin
         errors++;
         $display("FAIL irq_rise got edge %0d want edge %0d", rise - e, 21);
      end
      bus(1'b0, 3'd0, 32'd0, rdv, erv, acc);
      checks++;
      if (rdv !== 32'(acc - 1 - e)) begin
         errors++;
         $display("FAIL irq_mtime got %0d want %0d", rdv, acc - 1 - e);
      end
      wr(3'd2, 32'd100);
      checks++;
      if (timer_irq_pending !== 1'b0) begin
         errors++;
         $display("FAIL irq_fall got %b want 0", timer_irq_pending);
      end
   endtask

   // mtime = 2^64-2, cmp = 100: irq high while mtime >= 100, drops once mtime wraps to 0
   task automatic test_wrap();
      int e, d;
      logic exp;
      wr(3'd4, 32'd0);
      wr(3'd0, 32'hFFFF_FFFE);
      wr(3'd1, 32'hFFFF_FFFF);
      rd_expect("hi_keeps_lo", 3'd0, 32'hFFFF_FFFE);
      rd_expect("hi_written",  3'd1, 32'hFFFF_FFFF);
      wr(3'd4, 32'd1);
      e = acc;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp = ((cyc - e) <= 2);
         checks++;
         if (timer_irq_pending !== exp) begin
            errors++;
            $display("FAIL wrap_irq edge=%0d got %b want %b", cyc - e, timer_irq_pending, exp);
         end
      end
      wr(3'd4, 32'd0);
      d = acc;
      rd_expect("wrap_lo", 3'd0, 32'(d - e - 2));
      rd_expect("wrap_hi", 3'd1, 32'd0);
   endtask

   task automatic test_err();
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 3'd6;
      req_wdata = 32'd0;
      rsp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_hold k=%0d got vld=%b err=%b rdata=%h rdy=%b want 1 1 0 0",
                     k, rsp_valid, rsp_err, rsp_rdata, req_ready);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL err_release got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
      end
      bus(1'b1, 3'd7, 32'hFFFF_FFFF, rdv, erv, acc);
      checks++;
      if (erv !== 1'b1 || rdv !== 32'd0) begin
         errors++;
         $display("FAIL err_write got err=%b rdata=%h want 1 0", erv, rdv);
      end
      rd_expect("err_ctrl_same",     3'd4, 32'd0);
      rd_expect("err_prescale_same", 3'd5, 32'd0);
      rd_expect("err_cmp_same",      3'd2, 32'd100);
   endtask

   task automatic test_reset_mid();
      wr(3'd2, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd5, 32'd5);
      wr(3'd4, 32'd1);
      @(negedge clk);
      checks++;
      if (timer_irq_pending !== 1'b1) begin
         errors++;
         $display("FAIL pre_rst_irq got %b want 1", timer_irq_pending);
      end
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 3'd0;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || timer_irq_pending !== 1'b0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst got vld=%b rdy=%b irq=%b err=%b want 0 1 0 0",
                  rsp_valid, req_ready, timer_irq_pending, rsp_err);
      end
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      rd_expect("mid_rst_mtime",    3'd0, 32'd0);
      rd_expect("mid_rst_cmp_hi",   3'd3, 32'hFFFF_FFFF);
      rd_expect("mid_rst_ctrl",     3'd4, 32'd0);
      rd_expect("mid_rst_prescale", 3'd5, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 3'd0;
      req_wdata = 32'd0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_prescale();
      test_irq();
      test_wrap();
      test_err();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
